// File: rtl/seq_div_16x8.sv
// seq_div_16x8 -- 16-by-8 unsigned sequential divider (radix-2 restoring).
//
// One quotient bit is produced per clock, MSB first, so a division takes
// 16 CALC cycles followed by a single DONE cycle.
//
// Ports:
//   clk        rising-edge clock
//   sclr       synchronous active-high clear (overrides start)
//   start      start request, sampled only in IDLE
//   dividend   16-bit unsigned dividend, latched on the accepted start edge
//   divisor    8-bit unsigned divisor, latched on the accepted start edge
//   busy       high while iterating (CALC)
//   done       one-cycle completion pulse (DONE)
//   quotient   16-bit result, valid with done, held until the next start
//   remainder  8-bit result, valid with done, held until the next start
//   dz_err     divide-by-zero flag
//
// Build option:
//   SEQ_DIV_ZERO_DETECT_EN  when defined, a zero divisor skips the iteration
//                           and goes straight to DONE with quotient=16'hFFFF,
//                           remainder=dividend[7:0], dz_err=1. When undefined,
//                           a zero divisor iterates normally (yielding the same
//                           quotient/remainder) and dz_err is tied low.

module seq_div_16x8 (
  input  logic        clk,
  input  logic        sclr,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        dz_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [3:0]  cnt_q;
  logic [15:0] work_q;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [7:0]  prem_q;   // restored partial remainder
  logic [7:0]  dvsr_q;

  logic [8:0]  trial;
  logic        qbit;
  logic [7:0]  prem_next;
  logic [15:0] work_next;
  logic        zero_trap;
  logic        last_step;

`ifdef SEQ_DIV_ZERO_DETECT_EN
  assign zero_trap = (divisor == '0);
`else
  assign zero_trap = 1'b0;
`endif

  assign last_step = (cnt_q == 4'd15);

  // One restoring step. The 9-bit trial value is compared against the
  // zero-extended divisor; the restored remainder is always below the
  // divisor (or, for a zero divisor, just the low shifted bits), so it is
  // kept in 8 bits.
  always_comb begin
    trial     = {prem_q, work_q[15]};
    qbit      = (trial >= {1'b0, dvsr_q});
    prem_next = qbit ? 8'(trial - {1'b0, dvsr_q}) : trial[7:0];
    work_next = {work_q[14:0], qbit};
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = zero_trap ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      cnt_q     <= '0;
      work_q    <= '0;
      prem_q    <= '0;
      dvsr_q    <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if (state_q == IDLE) begin
        if (start) begin
          cnt_q  <= '0;
          work_q <= dividend;
          prem_q <= '0;
          dvsr_q <= divisor;
          if (zero_trap) begin
            quotient  <= '1;
            remainder <= dividend[7:0];
          end
        end
      end else if (state_q == CALC) begin
        cnt_q  <= cnt_q + 4'd1;
        work_q <= work_next;
        prem_q <= prem_next;
        // Results are published on the final step so they stay stable
        // through DONE and until the next operation completes.
        if (last_step) begin
          quotient  <= work_next;
          remainder <= prem_next;
        end
      end
    end
  end

`ifdef SEQ_DIV_ZERO_DETECT_EN
  always_ff @(posedge clk) begin
    if (sclr) begin
      dz_err <= 1'b0;
    end else if ((state_q == IDLE) && start) begin
      dz_err <= zero_trap;
    end
  end
`else
  assign dz_err = 1'b0;
`endif

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_div_16x8.sv
// tb_seq_div_16x8 -- directed and randomised checks for seq_div_16x8.
// Expectations for the zero-divisor case follow SEQ_DIV_ZERO_DETECT_EN.

module tb_seq_div_16x8;

  logic        clk;
  logic        sclr;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        dz_err;

  int n_checks;
  int n_errors;

  seq_div_16x8 dut (
    .clk       (clk),
    .sclr      (sclr),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz_err    (dz_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one operation. k counts edges after the start edge N (k=0 is the
  // cycle after N). poke_k >= 0 pulses a second start (50/5) at that cycle;
  // abort_k >= 0 asserts sclr after sampling that cycle.
  task automatic do_op(input string tag,
                       input logic [15:0] dvd, input logic [7:0] dvs,
                       input int poke_k, input int abort_k,
                       input logic [15:0] eq, input logic [7:0] er,
                       input logic edz, input int edone_k);
    int busy_n;
    bit seen;
    bit aborted;
    busy_n  = 0;
    seen    = 0;
    aborted = 0;
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k == 0) begin
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
      end
      chk($sformatf("%s_overlap_k%0d", tag, k), {31'd0, busy & done}, 32'd0);
      if (busy) busy_n++;
      if (abort_k >= 0 && k == abort_k + 1) begin
        chk($sformatf("%s_abort_busy", tag), {31'd0, busy}, 32'd0);
        chk($sformatf("%s_abort_done", tag), {31'd0, done}, 32'd0);
        chk($sformatf("%s_abort_q", tag), {16'd0, quotient}, 32'd0);
        chk($sformatf("%s_abort_r", tag), {24'd0, remainder}, 32'd0);
        chk($sformatf("%s_abort_dz", tag), {31'd0, dz_err}, 32'd0);
        sclr    = 1'b0;
        aborted = 1;
        break;
      end
      if (done) begin
        seen = 1;
        chk($sformatf("%s_done_k", tag), k, edone_k);
        chk($sformatf("%s_q", tag), {16'd0, quotient}, {16'd0, eq});
        chk($sformatf("%s_r", tag), {24'd0, remainder}, {24'd0, er});
        chk($sformatf("%s_dz", tag), {31'd0, dz_err}, {31'd0, edz});
        @(posedge clk);
        #1;
        chk($sformatf("%s_done_pulse", tag), {31'd0, done}, 32'd0);
        chk($sformatf("%s_busy_after", tag), {31'd0, busy}, 32'd0);
        chk($sformatf("%s_q_held", tag), {16'd0, quotient}, {16'd0, eq});
        chk($sformatf("%s_r_held", tag), {24'd0, remainder}, {24'd0, er});
        break;
      end
      if (k == abort_k) sclr = 1'b1;
      if (k == poke_k) begin
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 8'd5;
      end
    end
    if (aborted) begin
      for (int j = 0; j < 20; j++) begin
        @(posedge clk);
        #1;
        chk($sformatf("%s_no_done_%0d", tag, j), {30'd0, busy, done}, 32'd0);
      end
    end else begin
      chk($sformatf("%s_done_seen", tag), {31'd0, seen}, 32'd1);
      chk($sformatf("%s_busy_cycles", tag), busy_n, (edone_k == 0) ? 0 : 16);
    end
  endtask

  initial begin
    logic [15:0] rd;
    logic [7:0]  rs;
    int          dz_k;
    logic        dz_flag;
    n_checks = 0;
    n_errors = 0;
    sclr     = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", {16'd0, quotient}, 32'd0);
    chk("rst_r", {24'd0, remainder}, 32'd0);
    chk("rst_dz", {31'd0, dz_err}, 32'd0);

    // start coincident with sclr is discarded
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'd1000;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    sclr  = 1'b0;
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_start_busy2", {30'd0, busy, done}, 32'd0);

    do_op("basic",   16'd1000,  8'd7,   -1, -1, 16'd142,   8'd6,   1'b0, 16);
    do_op("max_1",   16'd65535, 8'd1,   -1, -1, 16'd65535, 8'd0,   1'b0, 16);
    do_op("max_255", 16'd65535, 8'd255, -1, -1, 16'd257,   8'd0,   1'b0, 16);
    do_op("small",   16'd5,     8'd9,   -1, -1, 16'd0,     8'd5,   1'b0, 16);
    do_op("zero_dd", 16'd0,     8'd5,   -1, -1, 16'd0,     8'd0,   1'b0, 16);
    do_op("d255_16", 16'd255,   8'd16,  -1, -1, 16'd15,    8'd15,  1'b0, 16);
    do_op("d54321",  16'd54321, 8'd123, -1, -1, 16'd441,   8'd78,  1'b0, 16);

`ifdef SEQ_DIV_ZERO_DETECT_EN
    dz_k    = 0;
    dz_flag = 1'b1;
`else
    dz_k    = 16;
    dz_flag = 1'b0;
`endif
    do_op("divzero", 16'h1234, 8'd0, -1, -1, 16'hFFFF, 8'h34, dz_flag, dz_k);
    // next nonzero-divisor start clears the flag
    do_op("dz_clear", 16'd40000, 8'd200, -1, -1, 16'd200, 8'd0, 1'b0, 16);

    do_op("busy_rej", 16'd1000, 8'd7, 8, -1, 16'd142, 8'd6, 1'b0, 16);
    do_op("abort",    16'd1000, 8'd7, -1, 10, 16'd0, 8'd0, 1'b0, 16);
    do_op("post_abort", 16'd200, 8'd3, -1, -1, 16'd66, 8'd2, 1'b0, 16);

    for (int i = 0; i < 1500; i++) begin
      rd = 16'($urandom_range(0, 65535));
      rs = 8'($urandom_range(1, 255));
      do_op($sformatf("rnd%0d", i), rd, rs, -1, -1, rd / 16'(rs), 8'(rd % 16'(rs)), 1'b0, 16);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
